// File: rtl/lapido_mem_unit_pkg.sv
// lapido_mem_unit_pkg: shared encodings, request record and lane helpers for the MEM stage
package lapido_mem_unit_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic {MEMU_IDLE = 1'b0, MEMU_WAIT = 1'b1} memu_state_e;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [1:0]            size;
    logic                  sgn;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] alu;
    logic [1:0]            wb;
  } memu_req_t;

  function automatic logic mem_misaligned(input logic rd, input logic wr, input logic [1:0] sz,
                                          input logic [1:0] a);
    return (rd & wr) | (sz == 2'b11) | (sz == MEM_HALF & a[0]) | (sz == MEM_WORD & a != 2'b00);
  endfunction

  function automatic logic [3:0] mem_be(input logic [1:0] sz, input logic [1:0] a);
    return sz == MEM_BYTE ? 4'b0001 << a : sz == MEM_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mem_wdata(input logic [1:0] sz,
                                                      input logic [DATA_WIDTH-1:0] d);
    return sz == MEM_BYTE ? {4{d[7:0]}} : sz == MEM_HALF ? {2{d[15:0]}} : d;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mem_load_ext(input logic [DATA_WIDTH-1:0] w,
                                                         input logic [1:0] a, input logic [1:0] sz,
                                                         input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    return sz == MEM_BYTE ? {{24{sg & b[7]}}, b} : sz == MEM_HALF ? {{16{sg & h[15]}}, h} : w;
  endfunction
endpackage

// File: rtl/lapido_mem_unit_dmem_bank.sv
// lapido_dmem_bank: single-port byte-enabled RAM with registered read, no reset
module lapido_dmem_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  input  logic                  we,
  input  logic                  re,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q, rdata_d;

  // read data only refreshes on a read so it holds across bubbles
  always_comb rdata_d = re ? mem[addr] : rdata_q;

  // byte-lane writes and read register
  always_ff @(posedge clk) begin
    if (we) for (int i = 0; i < 4; i++) if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/lapido_mem_unit.sv
// lapido_mem_unit: MEM stage with wait-state FSM, byte/half/word access and MEM/WB register
module lapido_mem_unit
  import lapido_mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1,
  parameter int REG_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_signed,
  input  logic [DATA_WIDTH-1:0] in_mem_addr,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic [REG_W-1:0]      in_reg_dst,
  input  logic [1:0]            in_wb_res_mux,
  output logic                  stall,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_mem_data,
  output logic [DATA_WIDTH-1:0] out_alu_res,
  output logic [REG_W-1:0]      out_reg_dst,
  output logic [1:0]            out_wb_res_mux,
  output logic                  misaligned
);
  memu_state_e           state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  memu_req_t             req_q, req_d, in_req, cur;
  logic [REG_W-1:0]      dst_q, dst_d, cur_dst, out_dst_q, out_dst_d;
  logic                  ov_q, ov_d, mis_q, mis_d, ld_q, ld_d, sgn_q, sgn_d;
  logic [1:0]            lane_q, lane_d, size_q, size_d, wb_q, wb_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d, rdata;
  logic                  accept, is_mem, bad, done, go_wait, we, re;

  // FSM next state, request capture, completion and MEM/WB register update
  always_comb begin
    in_req    = '{rd: mem_read, wr: mem_write, size: mem_size, sgn: mem_signed, addr: in_mem_addr,
                  data: in_mem_data, alu: in_alu_res, wb: in_wb_res_mux};
    accept    = in_valid && state_q == MEMU_IDLE;
    cur       = state_q == MEMU_WAIT ? req_q : in_req;
    cur_dst   = state_q == MEMU_WAIT ? dst_q : in_reg_dst;
    is_mem    = cur.rd | cur.wr;
    bad       = is_mem & mem_misaligned(cur.rd, cur.wr, cur.size, cur.addr[1:0]);
    go_wait   = accept && is_mem && WAIT_STATES != 0;
    done      = state_q == MEMU_WAIT ? cnt_q == 3'd0 : accept && !go_wait;
    state_d   = state_q == MEMU_WAIT ? (cnt_q == 3'd0 ? MEMU_IDLE : MEMU_WAIT)
                                     : (go_wait ? MEMU_WAIT : MEMU_IDLE);
    cnt_d     = state_q == MEMU_WAIT ? (cnt_q == 3'd0 ? 3'd0 : cnt_q - 3'd1)
                                     : (go_wait ? 3'(WAIT_STATES - 1) : 3'd0);
    req_d     = accept ? in_req : req_q;
    dst_d     = accept ? in_reg_dst : dst_q;
    we        = done & cur.wr & !bad;
    re        = done & cur.rd & !bad;
    ov_d      = done;
    mis_d     = done ? bad : mis_q;
    ld_d      = done ? re : ld_q;
    lane_d    = done ? cur.addr[1:0] : lane_q;
    size_d    = done ? cur.size : size_q;
    sgn_d     = done ? cur.sgn : sgn_q;
    alu_d     = done ? cur.alu : alu_q;
    wb_d      = done ? cur.wb : wb_q;
    out_dst_d = done ? cur_dst : out_dst_q;
  end

  // state and output registers; reset drops any pending access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MEMU_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      dst_q     <= '0;
      ov_q      <= 1'b0;
      mis_q     <= 1'b0;
      ld_q      <= 1'b0;
      lane_q    <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      alu_q     <= '0;
      wb_q      <= '0;
      out_dst_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      dst_q     <= dst_d;
      ov_q      <= ov_d;
      mis_q     <= mis_d;
      ld_q      <= ld_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      alu_q     <= alu_d;
      wb_q      <= wb_d;
      out_dst_q <= out_dst_d;
    end
  end

  lapido_dmem_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk  (clk),
    .addr (ADDR_WIDTH'(cur.addr >> 2)),
    .wdata(mem_wdata(cur.size, cur.data)),
    .be   (mem_be(cur.size, cur.addr[1:0])),
    .we   (we),
    .re   (re),
    .rdata(rdata)
  );

  assign stall          = state_q == MEMU_WAIT;
  assign out_valid      = ov_q;
  assign misaligned     = mis_q;
  assign out_mem_data   = ld_q ? mem_load_ext(rdata, lane_q, size_q, sgn_q) : '0;
  assign out_alu_res    = alu_q;
  assign out_reg_dst    = out_dst_q;
  assign out_wb_res_mux = wb_q;
endmodule

// File: tb/tb_lapido_mem_unit.sv
// tb_lapido_mem_unit: directed checks of three MEM-stage configurations
module tb_lapido_mem_unit;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        vld = '0;
  logic              rd = 1'b0, wr = 1'b0, sg = 1'b0;
  logic [1:0]        sz = '0, wb = '0;
  logic [31:0]       a = '0, d = '0, alu = '0;
  logic [4:0]        dst = '0;
  logic [2:0]        st_v, ov_v, mis_v;
  logic [2:0][31:0]  md_v, alu_v;
  logic [2:0][4:0]   dst_v;
  logic [2:0][1:0]   wb_v;
  logic [31:0]       patt;
  int                n_cmp = 0, n_bad = 0, lat, stl;

  lapido_mem_unit #(.ADDR_WIDTH(10), .WAIT_STATES(0), .REG_W(5)) u_w0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .mem_read(rd), .mem_write(wr), .mem_size(sz),
    .mem_signed(sg), .in_mem_addr(a), .in_mem_data(d), .in_alu_res(alu), .in_reg_dst(dst),
    .in_wb_res_mux(wb), .stall(st_v[0]), .out_valid(ov_v[0]), .out_mem_data(md_v[0]),
    .out_alu_res(alu_v[0]), .out_reg_dst(dst_v[0]), .out_wb_res_mux(wb_v[0]), .misaligned(mis_v[0]));

  lapido_mem_unit #(.ADDR_WIDTH(10), .WAIT_STATES(1), .REG_W(5)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .mem_read(rd), .mem_write(wr), .mem_size(sz),
    .mem_signed(sg), .in_mem_addr(a), .in_mem_data(d), .in_alu_res(alu), .in_reg_dst(dst),
    .in_wb_res_mux(wb), .stall(st_v[1]), .out_valid(ov_v[1]), .out_mem_data(md_v[1]),
    .out_alu_res(alu_v[1]), .out_reg_dst(dst_v[1]), .out_wb_res_mux(wb_v[1]), .misaligned(mis_v[1]));

  lapido_mem_unit #(.ADDR_WIDTH(4), .WAIT_STATES(3), .REG_W(5)) u_w3 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .mem_read(rd), .mem_write(wr), .mem_size(sz),
    .mem_signed(sg), .in_mem_addr(a), .in_mem_data(d), .in_alu_res(alu), .in_reg_dst(dst),
    .in_wb_res_mux(wb), .stall(st_v[2]), .out_valid(ov_v[2]), .out_mem_data(md_v[2]),
    .out_alu_res(alu_v[2]), .out_reg_dst(dst_v[2]), .out_wb_res_mux(wb_v[2]), .misaligned(mis_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // issue one op to instance k at a negedge, return at the negedge where out_valid is seen
  task automatic exec(input int k, input logic r, input logic w, input logic [1:0] s,
                      input logic g, input logic [31:0] ad, input logic [31:0] dt);
    rd = r; wr = w; sz = s; sg = g; a = ad; d = dt; vld[k] = 1'b1;
    @(negedge clk);
    vld[k] = 1'b0;
    lat = 1;
    stl = 0;
    while (!ov_v[k] && lat < 20) begin
      stl += int'(st_v[k]);
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) chk("timeout", 32'(lat), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(st_v), 32'd0);
    chk("rst_valid", 32'(ov_v), 32'd0);
    chk("rst_mis", 32'(mis_v), 32'd0);
    chk("rst_md", md_v[1], 32'd0);
    chk("rst_alu", alu_v[2], 32'd0);
    rst = 1'b1;
    @(negedge clk);

    exec(1, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    chk("w1_st_lat", 32'(lat), 32'd2);
    chk("w1_st_stall", 32'(stl), 32'd1);
    chk("w1_st_md", md_v[1], 32'd0);
    exec(1, 1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("w1_ld_lat", 32'(lat), 32'd2);
    chk("w1_ld_stall", 32'(stl), 32'd1);
    chk("w1_ld_md", md_v[1], 32'hDEADBEEF);
    chk("w1_ld_mis", 32'(mis_v[1]), 32'd0);

    exec(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    chk("w0_st_lat", 32'(lat), 32'd1);
    chk("w0_st_stall", 32'(stl), 32'd0);
    exec(0, 0, 1, 2'b00, 0, 32'h13, 32'h00000080);
    exec(0, 1, 0, 2'b00, 1, 32'h13, 32'h0);
    chk("lb_signed", md_v[0], 32'hFFFFFF80);
    exec(0, 1, 0, 2'b00, 0, 32'h13, 32'h0);
    chk("lb_unsigned", md_v[0], 32'h00000080);
    exec(0, 1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("lw_after_sb", md_v[0], 32'h80ADBEEF);
    exec(0, 1, 0, 2'b01, 1, 32'h12, 32'h0);
    chk("lh_signed_hi", md_v[0], 32'hFFFF80AD);
    exec(0, 1, 0, 2'b01, 0, 32'h10, 32'h0);
    chk("lh_unsigned_lo", md_v[0], 32'h0000BEEF);

    exec(0, 0, 1, 2'b10, 0, 32'h20, 32'h11223344);
    exec(0, 0, 1, 2'b01, 0, 32'h21, 32'h0000FFFF);
    chk("mis_sh_flag", 32'(mis_v[0]), 32'd1);
    chk("mis_sh_md", md_v[0], 32'd0);
    exec(0, 1, 0, 2'b10, 0, 32'h22, 32'h0);
    chk("mis_lw_flag", 32'(mis_v[0]), 32'd1);
    chk("mis_lw_md", md_v[0], 32'd0);
    exec(0, 1, 0, 2'b11, 0, 32'h20, 32'h0);
    chk("mis_sz3_flag", 32'(mis_v[0]), 32'd1);
    chk("mis_sz3_md", md_v[0], 32'd0);
    exec(0, 1, 1, 2'b10, 0, 32'h20, 32'hAAAAAAAA);
    chk("mis_rw_flag", 32'(mis_v[0]), 32'd1);
    exec(0, 1, 0, 2'b10, 0, 32'h20, 32'h0);
    chk("mis_word_kept", md_v[0], 32'h11223344);
    chk("mis_cleared", 32'(mis_v[0]), 32'd0);
    exec(0, 0, 1, 2'b00, 0, 32'h21, 32'h0000005A);
    exec(0, 0, 1, 2'b01, 0, 32'h22, 32'h0000BEEF);
    exec(0, 1, 0, 2'b10, 0, 32'h20, 32'h0);
    chk("lanes_merge", md_v[0], 32'hBEEF5A44);

    exec(2, 0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D);
    chk("w3_st_lat", 32'(lat), 32'd4);
    chk("w3_st_stall", 32'(stl), 32'd3);
    exec(2, 1, 0, 2'b10, 0, 32'h00, 32'h0);
    chk("wrap_ld", md_v[2], 32'hCAFEF00D);
    chk("w3_ld_lat", 32'(lat), 32'd4);

    rd = 1'b1; wr = 1'b0; sz = 2'b10; a = 32'h0; vld[2] = 1'b1; patt = '0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      patt[i] = ov_v[2];
    end
    vld[2] = 1'b0;
    chk("b2b_pattern", patt, 32'h110);
    repeat (5) @(negedge clk);

    alu = 32'h12345678; dst = 5'd7; wb = 2'd2;
    exec(2, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("alu_lat", 32'(lat), 32'd1);
    chk("alu_stall", 32'(stl), 32'd0);
    chk("alu_res", alu_v[2], 32'h12345678);
    chk("alu_dst", 32'(dst_v[2]), 32'd7);
    chk("alu_wb", 32'(wb_v[2]), 32'd2);
    chk("alu_md", md_v[2], 32'd0);

    rd = 1'b1; wr = 1'b0; sz = 2'b10; a = 32'h0; alu = 32'h0; vld[2] = 1'b1; patt = '0;
    @(negedge clk);
    rd = 1'b0; alu = 32'h0F0F0F0F; dst = 5'd9; wb = 2'd1;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      patt[i] = ov_v[2];
      if (i == 4) chk("ilv_ld_md", md_v[2], 32'hCAFEF00D);
      if (i == 5) begin
        chk("ilv_alu", alu_v[2], 32'h0F0F0F0F);
        chk("ilv_dst", 32'(dst_v[2]), 32'd9);
        vld[2] = 1'b0;
      end
    end
    chk("ilv_pattern", patt, 32'h30);
    chk("bubble_alu_hold", alu_v[2], 32'h0F0F0F0F);

    rd = 1'b0; wr = 1'b1; sz = 2'b10; a = 32'h0; d = 32'h55555555; vld[2] = 1'b1;
    @(negedge clk);
    vld[2] = 1'b0;
    chk("rstw_stall_before", 32'(st_v[2]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_stall", 32'(st_v[2]), 32'd0);
    chk("rstw_valid", 32'(ov_v[2]), 32'd0);
    chk("rstw_alu", alu_v[2], 32'd0);
    chk("rstw_dst", 32'(dst_v[2]), 32'd0);
    chk("rstw_md", md_v[2], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exec(2, 1, 0, 2'b10, 0, 32'h0, 32'h0);
    chk("rstw_dropped", md_v[2], 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lapido_mem_unit.md
# lapido_mem_unit

Parametrised MEM stage for the core_lapido pipeline, sitting between the EX/MEM register and the WB stage. It replaces the bare data memory with a byte-addressable, byte-enabled RAM that supports byte, half and word loads and stores, with sign or zero extension. It has a configurable wait-state FSM that stalls upstream, detects misaligned accesses, and registers results into the MEM/WB boundary. Non-memory instructions pass through with fixed one-cycle latency.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 1: extra cycles per memory access; legal range 0..7.
- `REG_W`, 5: destination-register index width.
- `clk`  in  1: clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: instruction present from EX/MEM.
- `mem_read` / `mem_write`  in  1 each: load / store; both high is illegal (treated as misaligned).
- `mem_size`  in  2: `MEM_BYTE`=00, `MEM_HALF`=01, `MEM_WORD`=10, 11 is illegal.
- `mem_signed`  in  1: sign-extend load (1) or zero-extend (0).
- `in_mem_addr`  in  32: byte address.
- `in_mem_data`  in  32: store data, right-aligned.
- `in_alu_res`  in  32: ALU result, passed through.
- `in_reg_dst`  in  REG_W: write-back register.
- `in_wb_res_mux`  in  2: WB select, passed through.
- `stall`  out  1: upstream must hold its inputs.
- `out_valid`  out  1: MEM/WB contents valid, one-cycle pulse per instruction.
- `out_mem_data`  out  32: extended load data; 0 for non-loads.
- `out_alu_res`, `out_reg_dst`, `out_wb_res_mux`  out: registered pass-through.
- `misaligned`  out  1: qualifies `out_valid`; access was suppressed.

## Operation
- The FSM has states `IDLE`, `WAIT`.
- **Accept.** An input is accepted at a rising edge where `in_valid`=1 and `stall`=0. Accepted fields are latched into an internal request register.
- **Non-memory op** (neither `mem_read` nor `mem_write`): results register at the accept edge. FSM stays `IDLE`.
- **Memory op, `WAIT_STATES`=0:** the access completes at the accept edge. FSM stays `IDLE`.
- **Memory op, `WAIT_STATES`>0:** the FSM goes `IDLE`→`WAIT` and the counter loads `WAIT_STATES`-1.
  - In `WAIT`, the counter decrements each edge.
  - On the edge where the counter is 0, the access completes and the FSM returns to `IDLE`.
- **Word index:** `in_mem_addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo the depth.
- **Alignment and byte lanes:** little-endian; byte lane = `addr[1:0]`, half lane = `addr[1]`.
- **Misaligned**, when any of these holds: half with `addr[0]`=1, word with `addr[1:0]`≠0, `mem_size`=11, or read and write both set.
  - Completes on the normal schedule, including wait states.
  - No RAM write; `out_mem_data`=0; `misaligned`=1 with `out_valid`.
- **Store:** the byte/half is replicated across lanes and written under byte enables at the completion edge. `out_mem_data`=0.
- **Load:** RAM is read at completion; the selected lane is extended per `mem_signed`.
- **Bubble:** with `in_valid`=0 and `stall`=0, `out_valid`=0 on the next cycle and the other outputs hold their last values.
- **Reset mid-access:** FSM→`IDLE`, counter 0, any pending store is dropped, all outputs 0. RAM contents are not cleared.

## Timing
- Reset values: `stall`=0, `out_valid`=0, `misaligned`=0, all data outputs 0.
- `stall` is registered and is high exactly while the FSM is in `WAIT`. There is no combinational path from inputs to `stall`.
- A memory op accepted at edge N:
  - `stall`=1 for cycles N..N+W-1 (W=`WAIT_STATES`).
  - Results register at edge N+W; `out_valid`=1 during the cycle after that edge.
  - A held next instruction is accepted at edge N+W+1, earliest.
- Throughput: non-memory ops, or any op with W=0, sustain 1 per cycle. Memory ops sustain 1 per W+1 cycles, as above.
- Inputs presented while `stall`=1 are ignored and must be held stable by upstream.

## Structure
- `lapido_defs.v` gains:
  - `MEM_BYTE`, `MEM_HALF`, `MEM_WORD`;
  - FSM encodings `MEMU_IDLE`, `MEMU_WAIT`;
  - `DATA_WIDTH` = 32.
- Sub-module `lapido_dmem_bank`: synchronous single-port RAM with 32-bit data, 4 byte-write enables and registered read. It has no reset.
- Lane select, extension and alignment checking stay in the top as combinational logic.

## Test plan
- **Word store/load, W=1:** store `0xDEADBEEF` to address 0x10, then load word from 0x10.
  - Expect: `stall` high 1 cycle per op; load `out_mem_data`=`0xDEADBEEF` with `out_valid`.
- **Byte lanes, W=0:** store byte `0x80` to 0x13, then load the byte signed and unsigned from 0x13.
  - Expect: `0xFFFFFF80` and `0x00000080`; a word load from 0x10 gives `0x80ADBEEF`.
- **Misaligned:** half store to 0x21, word load from 0x22, and `mem_size`=11.
  - Expect: each gives `misaligned`=1 and `out_mem_data`=0; a word read at 0x20 is unchanged.
- **Wrap and throughput, ADDR_WIDTH=4, W=3:**
  - Store to 0x40 then load from 0x00: the stored value is returned.
  - Back-to-back ops give `out_valid` every 4 cycles.
  - Interleaved ALU ops: pass-through fields arrive one cycle after acceptance.
- **Reset mid-`WAIT`:** W=3, drive `rst` low during the second stall cycle of a store.
  - Expect: outputs 0 immediately and `stall`=0; a subsequent load shows the old word, not the dropped store.
